hwpe_job_sequencer: RTL and testbench
=====================================

Name: hwpe_job_sequencer

Overview:
Queues accelerator job descriptors from the fabric controller and replays each one onto the HWPE peripheral (register-file) port. Per job: write N_JOB_REGS config words, write the trigger register, then wait for the HWPE done event before starting the next job. Sits between the FC-side job source and the HWPE periph port, next to the APB-to-periph bridge that feeds the same port. Removes per-job software polling.

Parameters:
N_JOB_REGS, 4, config words per job (1..16)
QUEUE_DEPTH, 4, job descriptors buffered (power of two, >=2)
REG_BASE, 32'h0000_0040, periph address of config word 0; word i at REG_BASE+4*i
TRIGGER_ADDR, 32'h0000_0000, periph address of HWPE trigger register
CNT_WIDTH, 16, width of completed-job counter
TIMEOUT_CYCLES, 65535, watchdog limit in WAIT_EVT (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
job_valid_i  in  1  descriptor push request
job_ready_o  out  1  queue not full
job_data_i  in  N_JOB_REGS*32  descriptor; word i in bits [32*i+31:32*i]
per_req_o  out  1  periph request
per_add_o  out  32  periph address
per_wen_o  out  1  0 = write (writes only; constant 0)
per_be_o  out  4  byte enable, constant 4'hF
per_wdata_o  out  32  write data
per_gnt_i  in  1  periph grant
per_r_valid_i  in  1  periph response valid (write ack)
evt_i  in  1  HWPE done event, single-cycle pulse
busy_o  out  1  FSM not IDLE or queue not empty
done_o  out  1  one-cycle pulse per completed job
error_o  out  1  sticky timeout flag (tied 0 without feature)
jobs_done_o  out  CNT_WIDTH  completed-job counter, wraps at 2^CNT_WIDTH
queue_level_o  out  $clog2(QUEUE_DEPTH)+1  descriptors queued

Behaviour:
- Reset: all outputs 0 except job_ready_o=1; queue empty, FSM IDLE, counters 0. Reset mid-job aborts immediately (per_req_o drops asynchronously); no drain.
- Queue: FIFO; push when job_valid_i & job_ready_o; job_ready_o = !full, registered, no combinational path from pop. Push and pop in the same cycle are both allowed; level unchanged. Push when full is ignored. Pointers wrap modulo QUEUE_DEPTH.
- FSM states: IDLE, WR_REQ, WR_RESP, TRIG_REQ, TRIG_RESP, WAIT_EVT, DONE.
- IDLE: if queue not empty, pop head into a working register; word index idx=0; go to WR_REQ the next cycle.
- WR_REQ: per_req_o=1, per_add_o=REG_BASE+4*idx, per_wdata_o=word[idx]. Hold all three stable until per_gnt_i. On gnt go to WR_RESP, req=0.
- WR_RESP: wait for per_r_valid_i. If idx==N_JOB_REGS-1, go to TRIG_REQ; else idx++ and go to WR_REQ. Only one transaction is outstanding. r_valid in the same cycle as gnt is not allowed by the protocol; a response is never expected before the following cycle.
- TRIG_REQ/TRIG_RESP: same handshake with per_add_o=TRIGGER_ADDR and per_wdata_o=0.
- WAIT_EVT: on evt_i go to DONE. evt_i in any other state is ignored.
- DONE: done_o=1 for one cycle; jobs_done_o++; go to IDLE. Best case per job is 2*(N_JOB_REGS+1)+3 cycles.
- Outputs are registered. per_add_o and per_wdata_o are 0 whenever per_req_o=0.

Optional Feature:
HWPE_SEQ_TIMEOUT_EN
- Defined: a watchdog counter clears on entry to WAIT_EVT and increments each cycle there. When it reaches TIMEOUT_CYCLES, set error_o (sticky until reset), go to DONE, pulse done_o, and still increment jobs_done_o.
- Not defined: no counter; WAIT_EVT waits forever; error_o tied 0.

Decomposition:
- Package hwpe_seq_pkg: FSM state enum, per_wen/be constants (WEN_WRITE=1'b0, BE_FULL=4'hF).
- One sub-module: hwpe_seq_fifo (parameterised width/depth descriptor FIFO with level output). The FSM and counters live in the top.

Test Plan:
- Single job, N_JOB_REGS=4, words A0..A3, gnt same cycle, r_valid +1 -> writes to 0x40,0x44,0x48,0x4C then 0x00; evt_i after 10 cycles -> done_o pulse, jobs_done_o=1, busy_o low the next cycle.
- Grant stall: gnt held low 5 cycles on word 2 -> per_add_o=0x48 and data stable for all 5 cycles, exactly one write per address.
- Queue full: push 5 jobs back-to-back with evt_i withheld -> job_ready_o=0 after 4 jobs in the queue plus 1 active. The 6th push is dropped. Then the jobs complete in push order: jobs_done_o=5.
- Simultaneous push/pop at level 1 -> queue_level_o stays 1; spurious evt_i during WR_RESP is ignored.
- rst_i asserted in WR_REQ -> per_req_o=0 asynchronously; after release, level=0 and jobs_done_o=0.
- With HWPE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, no evt_i -> error_o=1 and done_o pulse 100 cycles after entering WAIT_EVT; the next queued job proceeds.

Source files
------------

// File: rtl/hwpe_seq_pkg.sv
// Shared types and constants for the HWPE job sequencer.
// Optional watchdog is enabled in the top with HWPE_SEQ_TIMEOUT_EN.
package hwpe_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_TRIG_REQ,
    S_TRIG_RESP,
    S_WAIT_EVT,
    S_DONE
  } seq_state_e;

  localparam logic       WEN_WRITE = 1'b0;
  localparam logic [3:0] BE_FULL   = 4'hF;

  // Periph address of config word idx.
  function automatic logic [31:0] cfg_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/hwpe_seq_fifo.sv
// Descriptor FIFO with registered full flag and occupancy output.
module hwpe_seq_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned LW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             ready_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push_i && !full_q;
    do_pop  = pop_i && (level_q != '0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    // Power-of-two depth: pointer overflow is the modulo wrap.
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (!do_push && do_pop) begin
      level_d = level_q - 1'b1;
    end
    full_d = (level_d == LW'(DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign ready_o = !full_q;

endmodule

// File: rtl/hwpe_job_sequencer.sv
// Replays queued job descriptors onto the HWPE periph port, one job at a time.
// Define HWPE_SEQ_TIMEOUT_EN to add the WAIT_EVT watchdog and sticky error_o.
module hwpe_job_sequencer
  import hwpe_seq_pkg::*;
#(
  parameter int unsigned N_JOB_REGS     = 4,
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter logic [31:0] REG_BASE       = 32'h0000_0040,
  parameter logic [31:0] TRIGGER_ADDR   = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         job_valid_i,
  output logic                         job_ready_o,
  input  logic [N_JOB_REGS*32-1:0]     job_data_i,
  output logic                         per_req_o,
  output logic [31:0]                  per_add_o,
  output logic                         per_wen_o,
  output logic [3:0]                   per_be_o,
  output logic [31:0]                  per_wdata_o,
  input  logic                         per_gnt_i,
  input  logic                         per_r_valid_i,
  input  logic                         evt_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o,
  output logic [CNT_WIDTH-1:0]         jobs_done_o,
  output logic [$clog2(QUEUE_DEPTH):0] queue_level_o
);

  localparam int unsigned JW = N_JOB_REGS * 32;
  localparam int unsigned IW = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_JOB_REGS - 1);

  seq_state_e          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, next_idx;
  logic [JW-1:0]       job_q, job_d;
  logic                req_q, req_d;
  logic [31:0]         add_q, add_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                fifo_pop, fifo_empty;
  logic [JW-1:0]       fifo_rdata;
  logic                timeout;

  hwpe_seq_fifo #(
    .WIDTH (JW),
    .DEPTH (QUEUE_DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (job_valid_i),
    .wdata_i (job_data_i),
    .ready_o (job_ready_o),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .level_o (queue_level_o)
  );

`ifdef HWPE_SEQ_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;

  always_comb begin
    err_d   = err_q;
    timeout = (state_q == S_WAIT_EVT) && (wd_q == WDW'(TIMEOUT_CYCLES - 1));
    // Held at zero outside WAIT_EVT, so it is cleared on every entry.
    wd_d    = (state_q == S_WAIT_EVT) ? wd_q + 1'b1 : '0;
    if (timeout && !evt_i) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign error_o = err_q;
`else
  assign timeout = 1'b0;
  // TIMEOUT_CYCLES only matters when the watchdog is built in.
  assign error_o = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    job_d    = job_q;
    req_d    = req_q;
    add_d    = add_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    next_idx = idx_q + 1'b1;

    // Periph outputs are registered, so they are loaded on the transition
    // into each *_REQ state and cleared on the grant that leaves it.
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          job_d    = fifo_rdata;
          idx_d    = '0;
          state_d  = S_WR_REQ;
          req_d    = 1'b1;
          add_d    = REG_BASE;
          wdata_d  = fifo_rdata[31:0];
        end
      end
      S_WR_REQ: begin
        if (per_gnt_i) begin
          state_d = S_WR_RESP;
          req_d   = 1'b0;
          add_d   = '0;
          wdata_d = '0;
        end
      end
      S_WR_RESP: begin
        if (per_r_valid_i) begin
          req_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_TRIG_REQ;
            add_d   = TRIGGER_ADDR;
            wdata_d = '0;
          end else begin
            idx_d   = next_idx;
            state_d = S_WR_REQ;
            add_d   = cfg_addr(REG_BASE, 32'(next_idx));
            wdata_d = job_q[32*next_idx +: 32];
          end
        end
      end
      S_TRIG_REQ: begin
        if (per_gnt_i) begin
          state_d = S_TRIG_RESP;
          req_d   = 1'b0;
          add_d   = '0;
          wdata_d = '0;
        end
      end
      S_TRIG_RESP: begin
        if (per_r_valid_i) state_d = S_WAIT_EVT;
      end
      S_WAIT_EVT: begin
        if (evt_i || timeout) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      job_q   <= '0;
      req_q   <= 1'b0;
      add_q   <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      job_q   <= job_d;
      req_q   <= req_d;
      add_q   <= add_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign per_req_o   = req_q;
  assign per_add_o   = add_q;
  assign per_wdata_o = wdata_q;
  assign per_wen_o   = WEN_WRITE;
  assign per_be_o    = BE_FULL;
  assign done_o      = done_q;
  assign jobs_done_o = cnt_q;
  assign busy_o      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_hwpe_job_sequencer.sv
// Self-checking bench for hwpe_job_sequencer: vector table, corner sequences, random jobs.
`timescale 1ns/1ps
module tb_hwpe_job_sequencer;

  localparam int unsigned NREG       = 4;
  localparam int unsigned QD         = 4;
  localparam int unsigned CW         = 16;
  localparam int unsigned TB_TIMEOUT = 100;
  localparam int unsigned JW         = NREG * 32;
  localparam int unsigned LW         = $clog2(QD) + 1;
  localparam logic [31:0] RBASE      = 32'h0000_0040;
  localparam logic [31:0] TADDR      = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          job_valid_i;
  logic          job_ready_o;
  logic [JW-1:0] job_data_i;
  logic          per_req_o;
  logic [31:0]   per_add_o;
  logic          per_wen_o;
  logic [3:0]    per_be_o;
  logic [31:0]   per_wdata_o;
  logic          per_gnt_i;
  logic          per_r_valid_i;
  logic          evt_i;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [CW-1:0] jobs_done_o;
  logic [LW-1:0] queue_level_o;

  always #5 clk = ~clk;

  hwpe_job_sequencer #(
    .N_JOB_REGS     (NREG),
    .QUEUE_DEPTH    (QD),
    .REG_BASE       (RBASE),
    .TRIGGER_ADDR   (TADDR),
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .job_valid_i   (job_valid_i),
    .job_ready_o   (job_ready_o),
    .job_data_i    (job_data_i),
    .per_req_o     (per_req_o),
    .per_add_o     (per_add_o),
    .per_wen_o     (per_wen_o),
    .per_be_o      (per_be_o),
    .per_wdata_o   (per_wdata_o),
    .per_gnt_i     (per_gnt_i),
    .per_r_valid_i (per_r_valid_i),
    .evt_i         (evt_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .jobs_done_o   (jobs_done_o),
    .queue_level_o (queue_level_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int unsigned   gd;
    int unsigned   rd;
    int unsigned   ed;
    int unsigned   lat;
    logic [JW-1:0] data;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  wr_t  exp_q[$];
  int   exp_jobs = 0;

  int          gnt_delay = 0, rv_delay = 0, evt_delay = 0;
  bit          rand_delays = 0, auto_evt = 1, spurious = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_len = 0;
  int          evt_req = 0, evt_ack = 0;
  int          trig_rv_cyc = 0;

  logic        prev_req, prev_gnt, prev_done;
  logic [31:0] prev_add, prev_wd;
  int          done_count, done_cyc, req48_cycles;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Reference: every accepted job produces N config writes then one trigger write.
  task automatic push_expect(input logic [JW-1:0] d);
    for (int i = 0; i < NREG; i++) exp_q.push_back('{RBASE + 32'(4 * i), d[32*i +: 32]});
    exp_q.push_back('{TADDR, 32'h0});
  endtask

  task automatic push_job(input logic [JW-1:0] d, output int p);
    job_data_i  = d;
    job_valid_i = 1'b1;
    p = cyc + 1;
    push_expect(d);
    step();
    job_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_count < target && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(done_count >= target), 32'd1);
  endtask

  function automatic logic [JW-1:0] rand_job();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : responder
    logic [31:0] a;
    int gd, rd, ed;
    per_gnt_i = 1'b0;
    per_r_valid_i = 1'b0;
    evt_i = 1'b0;
    @(negedge clk);
    forever begin
      if (per_req_o && !rst_i) begin
        evt_i = 1'b0;
        a  = per_add_o;
        gd = rand_delays ? int'($urandom_range(0, 3)) : gnt_delay;
        rd = rand_delays ? int'($urandom_range(0, 3)) : rv_delay;
        if (a == stall_addr) gd = stall_len;
        repeat (gd) @(negedge clk);
        per_gnt_i = 1'b1;
        @(negedge clk);
        per_gnt_i = 1'b0;
        if (spurious) begin
          evt_i = 1'b1;
          @(negedge clk);
          evt_i = 1'b0;
        end
        repeat (rd) @(negedge clk);
        per_r_valid_i = 1'b1;
        if (a == TADDR) trig_rv_cyc = cyc + 1;
        @(negedge clk);
        per_r_valid_i = 1'b0;
        if (a == TADDR && auto_evt) begin
          ed = rand_delays ? int'($urandom_range(0, 8)) : evt_delay;
          repeat (ed) @(negedge clk);
          evt_i = 1'b1;
          @(negedge clk);
          evt_i = 1'b0;
        end
      end else begin
        evt_i = (evt_req != evt_ack);
        if (evt_i) evt_ack++;
        @(negedge clk);
      end
    end
  end

  initial begin : monitor
    wr_t e;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_done = 1'b0;
    prev_add = '0; prev_wd = '0;
    done_count = 0; done_cyc = 0; req48_cycles = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_i) begin
        if (!per_req_o) begin
          check("idle_addr_zero", per_add_o, 32'h0);
          check("idle_wdata_zero", per_wdata_o, 32'h0);
        end else begin
          if (per_add_o == 32'h48) req48_cycles++;
          if (prev_req && !prev_gnt) begin
            check("hold_addr", per_add_o, prev_add);
            check("hold_wdata", per_wdata_o, prev_wd);
          end
          if (per_gnt_i) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write: got addr %h data %h, expected no write", per_add_o, per_wdata_o);
            end else begin
              e = exp_q.pop_front();
              check("wr_addr", per_add_o, e.addr);
              check("wr_data", per_wdata_o, e.data);
            end
          end
        end
        if (done_o) begin
          done_count++;
          done_cyc = cyc;
          if (prev_done) begin
            checks++;
            errors++;
            $display("FAIL done_width: got done_o high 2 cycles, expected 1");
          end
        end
      end
      prev_req  = per_req_o;
      prev_gnt  = per_gnt_i;
      prev_add  = per_add_o;
      prev_wd   = per_wdata_o;
      prev_done = done_o;
    end
  end

  initial begin : global_guard
    #3ms;
    $display("FAIL global_timeout: got no finish, expected finish before 3ms");
    $fatal(1, "bench timeout");
  end

  vec_t vecs [6];
  int   exp_lvl [6] = '{1, 1, 2, 3, 4, 4};
  int   exp_rdy [6] = '{1, 1, 1, 1, 0, 0};

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},   32'(per_req_o), 32'd0);
    check({tag, "_add"},   per_add_o, 32'h0);
    check({tag, "_ready"}, 32'(job_ready_o), 32'd1);
    check({tag, "_busy"},  32'(busy_o), 32'd0);
    check({tag, "_done"},  32'(done_o), 32'd0);
    check({tag, "_error"}, 32'(error_o), 32'd0);
    check({tag, "_jobs"},  32'(jobs_done_o), 32'd0);
    check({tag, "_level"}, 32'(queue_level_o), 32'd0);
  endtask

  initial begin : main
    int p, base, n, k;
    logic [JW-1:0] d;

    vecs[0] = '{0, 0, 10, 22, {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}};
    vecs[1] = '{0, 0, 0, 12, rand_job()};
    vecs[2] = '{1, 0, 0, 17, rand_job()};
    vecs[3] = '{0, 2, 0, 22, rand_job()};
    vecs[4] = '{2, 1, 3, 30, rand_job()};
    vecs[5] = '{3, 3, 0, 42, rand_job()};

    rst_i = 1'b1;
    job_valid_i = 1'b0;
    job_data_i = '0;
    repeat (3) step();
    check_reset_state("reset");
    check("reset_wen", 32'(per_wen_o), 32'd0);
    check("reset_be", 32'(per_be_o), 32'hF);
    rst_i = 1'b0;
    step();
    check_reset_state("post_reset");

    // Table: handshake delays versus push-to-done latency.
    for (int v = 0; v < 6; v++) begin
      gnt_delay = int'(vecs[v].gd);
      rv_delay  = int'(vecs[v].rd);
      evt_delay = int'(vecs[v].ed);
      base = done_count;
      push_job(vecs[v].data, p);
      exp_jobs++;
      wait_done(base + 1, 500, "vec_done");
      check("vec_latency", 32'(done_cyc - p), vecs[v].lat);
      check("vec_jobs", 32'(jobs_done_o), 32'(exp_jobs));
      step();
      check("vec_busy_low", 32'(busy_o), 32'd0);
      check("vec_done_low", 32'(done_o), 32'd0);
    end
    gnt_delay = 0; rv_delay = 0; evt_delay = 0;

    // Grant withheld 5 cycles on config word 2.
    stall_addr = 32'h48;
    stall_len = 5;
    req48_cycles = 0;
    base = done_count;
    push_job(rand_job(), p);
    exp_jobs++;
    wait_done(base + 1, 500, "stall_done");
    check("stall_req_cycles", 32'(req48_cycles), 32'd6);
    check("stall_jobs", 32'(jobs_done_o), 32'(exp_jobs));
    stall_addr = 32'hFFFF_FFFF;
    step();

    // Back-to-back pushes until full; 6th push is dropped.
    evt_delay = 20;
    base = done_count;
    job_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = rand_job();
      job_data_i = d;
      if (i < QD + 1) push_expect(d);
      step();
      check("fill_level", 32'(queue_level_o), 32'(exp_lvl[i]));
      check("fill_ready", 32'(job_ready_o), 32'(exp_rdy[i]));
    end
    job_valid_i = 1'b0;
    exp_jobs += QD + 1;
    wait_done(base + QD + 1, 2000, "fill_done");
    repeat (30) step();
    check("fill_jobs", 32'(jobs_done_o), 32'(exp_jobs));
    check("fill_drained", 32'(exp_q.size()), 32'd0);
    check("fill_level_end", 32'(queue_level_o), 32'd0);
    evt_delay = 0;

    // Spurious evt_i during every response wait must not finish the job.
    spurious = 1'b1;
    auto_evt = 1'b0;
    base = done_count;
    push_job(rand_job(), p);
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin step(); n++; end
    repeat (20) step();
    check("spur_no_done", 32'(done_count), 32'(base));
    check("spur_busy", 32'(busy_o), 32'd1);
    check("spur_jobs", 32'(jobs_done_o), 32'(exp_jobs));
    spurious = 1'b0;
    evt_req++;
    exp_jobs++;
    wait_done(base + 1, 100, "spur_done");
    check("spur_jobs_after", 32'(jobs_done_o), 32'(exp_jobs));
    auto_evt = 1'b1;
    step();

    // Random job bursts with random handshake timing.
    rand_delays = 1'b1;
    for (int r = 0; r < 8; r++) begin
      k = int'($urandom_range(1, QD + 1));
      base = done_count;
      job_valid_i = 1'b1;
      for (int i = 0; i < k; i++) begin
        d = rand_job();
        job_data_i = d;
        push_expect(d);
        step();
      end
      job_valid_i = 1'b0;
      exp_jobs += k;
      wait_done(base + k, 3000, "rand_done");
      step();
      check("rand_jobs", 32'(jobs_done_o), 32'(exp_jobs));
      check("rand_busy_low", 32'(busy_o), 32'd0);
    end
    rand_delays = 1'b0;
    check("rand_drained", 32'(exp_q.size()), 32'd0);

`ifdef HWPE_SEQ_TIMEOUT_EN
    // No evt_i: watchdog completes each job 100 cycles into WAIT_EVT.
    auto_evt = 1'b0;
    base = done_count;
    job_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      d = rand_job();
      job_data_i = d;
      push_expect(d);
      step();
    end
    job_valid_i = 1'b0;
    wait_done(base + 1, 400, "to_done1");
    check("to_delay1", 32'(done_cyc - trig_rv_cyc), TB_TIMEOUT);
    check("to_error", 32'(error_o), 32'd1);
    exp_jobs++;
    check("to_jobs1", 32'(jobs_done_o), 32'(exp_jobs));
    wait_done(base + 2, 400, "to_done2");
    check("to_delay2", 32'(done_cyc - trig_rv_cyc), TB_TIMEOUT);
    exp_jobs++;
    check("to_jobs2", 32'(jobs_done_o), 32'(exp_jobs));
    check("to_error_sticky", 32'(error_o), 32'd1);
    auto_evt = 1'b1;
    step();
`else
    check("no_watchdog_error", 32'(error_o), 32'd0);
`endif

    // Reset while requesting config word 1 aborts the job immediately.
    stall_addr = 32'h44;
    stall_len = 8;
    push_job(rand_job(), p);
    n = 0;
    while (!(per_req_o && per_add_o == 32'h44) && n < 200) begin step(); n++; end
    check("rst_reach_wr_req", 32'(per_req_o && per_add_o == 32'h44), 32'd1);
    #1 rst_i = 1'b1;
    #1 check("rst_async_req", 32'(per_req_o), 32'd0);
    repeat (3) step();
    rst_i = 1'b0;
    exp_q.delete();
    exp_jobs = 0;
    stall_addr = 32'hFFFF_FFFF;
    step();
    check_reset_state("mid_job_reset");
    repeat (15) step();
    base = done_count;
    push_job(rand_job(), p);
    exp_jobs++;
    wait_done(base + 1, 500, "post_rst_done");
    check("post_rst_jobs", 32'(jobs_done_o), 32'(exp_jobs));
    repeat (5) step();
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
